// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 and pulses tick on the last count.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, start + DATA_BITS (LSB first) + stop, valid/ready input.
//   state | meaning
//   IDLE  | line idle high, tx_ready follows ena
//   START | start bit for one bit period
//   DATA  | payload bits, one bit period each
//   STOP  | stop bit for one bit period
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8) begin : g_param_check
    $error("uart_tx: illegal parameters CLK_DIV=%0d DATA_BITS=%0d", CLK_DIV, DATA_BITS);
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 tick, baud_clear, tx_nxt, busy_nxt;

  assign tx_ready   = ena && (state == IDLE);
  assign baud_clear = !ena || (state == IDLE);

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  // tx/busy are registered from the current state, so the line trails the FSM by
  // one cycle; tx_ready therefore rises during the last stop-bit cycle, which gives
  // back-to-back frames exactly one idle cycle between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = UART_IDLE_LEVEL;
    busy_nxt    = 1'b0;
    if (!ena) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      busy_nxt = (state != IDLE);
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state_nxt = START;
            shreg_nxt = tx_data;
          end
        end
        START: begin
          tx_nxt = UART_START_LEVEL;
          if (tick) state_nxt = DATA;
        end
        DATA: begin
          tx_nxt = shreg[0];
          if (tick) begin
            shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_nxt = '0;
              state_nxt   = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          tx_nxt = UART_STOP_LEVEL;
          if (tick) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: index 0 is CLK_DIV=4/8 bits, 1..6 sweep CLK_DIV x DATA_BITS.
module tb_uart_tx;

  localparam int N = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d_arr    [N];
  logic       v_arr    [N];
  logic       e_arr    [N];
  logic       rdy_arr  [N];
  logic       tx_arr   [N];
  logic       busy_arr [N];

  int tests = 0;
  int fails = 0;

  function automatic int cd_of(input int g);
    if (g == 0) return 4;
    if (g <= 2) return 2;
    if (g <= 4) return 3;
    return 16;
  endfunction

  function automatic int db_of(input int g);
    if (g == 0) return 8;
    return (g % 2 == 1) ? 5 : 8;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CDV = cd_of(g);
    localparam int DBV = db_of(g);
    uart_tx #(
      .CLK_DIV  (CDV),
      .DATA_BITS(DBV)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (e_arr[g]),
      .tx_data (d_arr[g][DBV-1:0]),
      .tx_valid(v_arr[g]),
      .tx_ready(rdy_arr[g]),
      .tx      (tx_arr[g]),
      .busy    (busy_arr[g])
    );
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Call with tx_valid already high; returns 1ns after the accepting edge.
  task automatic wait_accept(input int g, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (rdy_arr[g] === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: handshake timeout, tx_ready low for 1000 cycles, required high", name);
    end
  endtask

  // Receiver model, started 1ns after the accepting edge: cycle 0 must still be idle,
  // then (DATA_BITS+2)*CLK_DIV cycles of frame, each bit constant over its period.
  task automatic rx_frame(input int g, output logic [7:0] data, output int len,
                          output int shape_err);
    int   cd, db;
    logic first, s;
    cd = cd_of(g);
    db = db_of(g);
    data = '0;
    len = 0;
    shape_err = 0;
    first = 1'b1;
    @(negedge clk);
    if (tx_arr[g] !== 1'b1 || busy_arr[g] !== 1'b0) shape_err++;
    for (int b = 0; b < db + 2; b++) begin
      for (int c = 0; c < cd; c++) begin
        @(negedge clk);
        s = tx_arr[g];
        if (busy_arr[g] === 1'b1) len++;
        if (c == 0) begin
          first = s;
          if (b == 0 && s !== 1'b0) shape_err++;
          else if (b == db + 1 && s !== 1'b1) shape_err++;
          else if (b >= 1 && b <= db) data[b-1] = s;
        end else if (s !== first) begin
          shape_err++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (tx_arr[0] !== 1'b1 || busy_arr[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: tx=%b busy=%b, required tx=1 busy=0", tx_arr[0], busy_arr[0]);
    end
    tests++;
    if (rdy_arr[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_ena1: tx_ready=%b, required 1", rdy_arr[0]);
    end
    e_arr[0] = 1'b0;
    #1;
    tests++;
    if (rdy_arr[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_ena0: tx_ready=%b, required 0", rdy_arr[0]);
    end
    e_arr[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    int len, serr, rdy_hi;
    rdy_hi = 0;
    @(posedge clk);
    #1;
    d_arr[0] = 8'hA5;
    v_arr[0] = 1'b1;
    wait_accept(0, "single_accept");
    v_arr[0] = 1'b0;
    fork
      rx_frame(0, got, len, serr);
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (rdy_arr[0] !== 1'b0) rdy_hi++;
      end
    join
    tests++;
    if (got !== 8'hA5) begin
      fails++;
      $display("FAIL single_data: decoded %h, required a5", got);
    end
    tests++;
    if (len != 40) begin
      fails++;
      $display("FAIL single_busy_len: busy high %0d cycles, required 40", len);
    end
    tests++;
    if (serr != 0) begin
      fails++;
      $display("FAIL single_shape: %0d bad line samples, required 0", serr);
    end
    tests++;
    if (rdy_hi != 0) begin
      fails++;
      $display("FAIL single_ready_low: tx_ready high in %0d frame cycles, required 0", rdy_hi);
    end
    @(negedge clk);
    tests++;
    if (busy_arr[0] !== 1'b0 || tx_arr[0] !== 1'b1 || rdy_arr[0] !== 1'b1) begin
      fails++;
      $display("FAIL single_after: busy=%b tx=%b ready=%b, required 0 1 1",
               busy_arr[0], tx_arr[0], rdy_arr[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2;
    int l1, l2, s1, s2;
    @(posedge clk);
    #1;
    d_arr[0] = 8'h00;
    v_arr[0] = 1'b1;
    wait_accept(0, "b2b_first");
    fork
      begin
        rx_frame(0, g1, l1, s1);
        rx_frame(0, g2, l2, s2);
      end
      begin
        d_arr[0] = 8'hFF;
        wait_accept(0, "b2b_second");
        v_arr[0] = 1'b0;
      end
    join
    tests++;
    if (g1 !== 8'h00 || g2 !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_data: decoded %h %h, required 00 ff", g1, g2);
    end
    tests++;
    if (l1 != 40 || l2 != 40) begin
      fails++;
      $display("FAIL b2b_len: busy %0d/%0d cycles, required 40/40", l1, l2);
    end
    tests++;
    if (s1 != 0 || s2 != 0) begin
      fails++;
      $display("FAIL b2b_gap_shape: bad samples %0d/%0d, required 0/0 (one idle cycle)", s1, s2);
    end
  endtask

  task automatic test_stall();
    logic [7:0] g1, g2;
    int l1, l2, s1, s2, early;
    early = 0;
    @(posedge clk);
    #1;
    d_arr[0] = 8'h5A;
    v_arr[0] = 1'b1;
    wait_accept(0, "stall_first");
    v_arr[0] = 1'b0;
    fork
      begin
        rx_frame(0, g1, l1, s1);
        rx_frame(0, g2, l2, s2);
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        d_arr[0] = 8'h3C;
        v_arr[0] = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (rdy_arr[0] !== 1'b0) early++;
        end
        wait_accept(0, "stall_second");
        v_arr[0] = 1'b0;
      end
    join
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL stall_ready: tx_ready high %0d cycles mid-frame, required 0", early);
    end
    tests++;
    if (g1 !== 8'h5A || s1 != 0) begin
      fails++;
      $display("FAIL stall_inflight: decoded %h bad=%0d, required 5a bad=0", g1, s1);
    end
    tests++;
    if (g2 !== 8'h3C || s2 != 0 || l2 != 40) begin
      fails++;
      $display("FAIL stall_next: decoded %h bad=%0d len=%0d, required 3c 0 40", g2, s2, l2);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int len, serr;
    @(posedge clk);
    #1;
    d_arr[0] = 8'h00;
    v_arr[0] = 1'b1;
    wait_accept(0, "abort_first");
    v_arr[0] = 1'b0;
    repeat (19) @(negedge clk);
    tests++;
    if (busy_arr[0] !== 1'b1 || tx_arr[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_pre: busy=%b tx=%b in data bit 3, required 1 0", busy_arr[0], tx_arr[0]);
    end
    e_arr[0] = 1'b0;
    #1;
    tests++;
    if (rdy_arr[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_ready: tx_ready=%b with ena low, required 0", rdy_arr[0]);
    end
    @(negedge clk);
    tests++;
    if (tx_arr[0] !== 1'b1 || busy_arr[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_next: tx=%b busy=%b, required 1 0", tx_arr[0], busy_arr[0]);
    end
    e_arr[0] = 1'b1;
    @(posedge clk);
    #1;
    d_arr[0] = 8'h81;
    v_arr[0] = 1'b1;
    wait_accept(0, "abort_resend");
    v_arr[0] = 1'b0;
    rx_frame(0, got, len, serr);
    tests++;
    if (got !== 8'h81 || len != 40 || serr != 0) begin
      fails++;
      $display("FAIL abort_resend: decoded %h len=%0d bad=%0d, required 81 40 0", got, len, serr);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk);
      #1;
      d_arr[0] = 8'h55;
      v_arr[0] = 1'b1;
      wait_accept(0, "rst_send");
      v_arr[0] = 1'b0;
      // pass 0 lands in the start bit (tx low), pass 1 in the stop bit
      repeat ((pass == 0) ? 3 : 39) @(negedge clk);
      tests++;
      if (busy_arr[0] !== 1'b1 || tx_arr[0] !== ((pass == 0) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL rst_pre%0d: busy=%b tx=%b, required busy=1 tx=%b", pass,
                 busy_arr[0], tx_arr[0], (pass == 0) ? 1'b0 : 1'b1);
      end
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (tx_arr[0] !== 1'b1 || busy_arr[0] !== 1'b0) begin
        fails++;
        $display("FAIL rst_async%0d: tx=%b busy=%b, required 1 0", pass, tx_arr[0], busy_arr[0]);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (rdy_arr[0] !== 1'b1 || busy_arr[0] !== 1'b0 || tx_arr[0] !== 1'b1) begin
        fails++;
        $display("FAIL rst_release%0d: ready=%b busy=%b tx=%b, required 1 0 1", pass,
                 rdy_arr[0], busy_arr[0], tx_arr[0]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] b, got, mask;
    int len, serr, exp_len;
    for (int g = 1; g < N; g++) begin
      mask = 8'((1 << db_of(g)) - 1);
      exp_len = (db_of(g) + 2) * cd_of(g);
      for (int k = 0; k < 50; k++) begin
        b = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        d_arr[g] = b;
        v_arr[g] = 1'b1;
        wait_accept(g, "sweep_accept");
        v_arr[g] = 1'b0;
        rx_frame(g, got, len, serr);
        tests++;
        if (got !== (b & mask)) begin
          fails++;
          $display("FAIL sweep_data cd=%0d db=%0d k=%0d: decoded %h, required %h",
                   cd_of(g), db_of(g), k, got, b & mask);
        end
        tests++;
        if (len != exp_len) begin
          fails++;
          $display("FAIL sweep_len cd=%0d db=%0d k=%0d: busy %0d cycles, required %0d",
                   cd_of(g), db_of(g), k, len, exp_len);
        end
        tests++;
        if (serr != 0) begin
          fails++;
          $display("FAIL sweep_shape cd=%0d db=%0d k=%0d: %0d bad samples, required 0",
                   cd_of(g), db_of(g), k, serr);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      e_arr[g] = 1'b1;
      v_arr[g] = 1'b0;
      d_arr[g] = 8'h00;
    end
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid_frame();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
